// File: rtl/fifo_wr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl_pkg
// Shared definitions for the asynchronous FIFO pointer controllers (write and
// read side). Provides:
//   - default address width, depth and almost-full threshold
//   - ptr_width(): pointer width for a given address width (ADDR_WIDTH + 1)
//   - bin_to_gray() / gray_to_bin(): conversions on a 32-bit container; callers
//     zero-extend narrower pointers in and truncate the result back out, which
//     is exact because both conversions only propagate towards the LSB.
// -----------------------------------------------------------------------------
package fifo_wr_ctrl_pkg;

  localparam int DEFAULT_ADDR_WIDTH   = 3;
  localparam int DEFAULT_DEPTH        = 1 << DEFAULT_ADDR_WIDTH;
  localparam int DEFAULT_AFULL_THRESH = 6;
  localparam int MAX_PTR_WIDTH        = 32;

  typedef logic [MAX_PTR_WIDTH-1:0] ptr_word_t;

  // One extra bit distinguishes full from empty when the address bits match.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam int PTR_WIDTH = ptr_width(DEFAULT_ADDR_WIDTH);

  function automatic ptr_word_t bin_to_gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray_to_bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[MAX_PTR_WIDTH-1] = gray[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage : fifo_wr_ctrl_pkg

// File: rtl/fifo_wr_ctrl_gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Combinational Gray-to-binary converter of parameterized width.
// Ports:
//   gray  in  WIDTH  Gray-coded value
//   bin   out WIDTH  equivalent binary value
// -----------------------------------------------------------------------------
module gray2bin
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int WIDTH = PTR_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = WIDTH'(gray_to_bin(MAX_PTR_WIDTH'(gray)));
  end

endmodule : gray2bin

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side pointer and full-flag controller of the asynchronous FIFO. Runs
// entirely in the write clock domain; owns the binary and Gray write pointers.
//
// Optional feature: define FIFO_WR_ALMOST_FULL_EN to compile in the occupancy
// compare behind w_almost_full. Without it w_almost_full is tied to 0.
//
// Ports:
//   clk            in   write-domain clock
//   rst            in   synchronous active-high reset
//   w_inc          in   producer write request (one word per cycle)
//   sync_rptr      in   Gray read pointer, already synchronized into clk
//   w_en           out  memory write enable (combinational, w_inc & ~w_full)
//   w_addr         out  memory write address (low bits of binary pointer)
//   wptr           out  registered Gray write pointer for the read domain
//   w_full         out  registered full flag
//   w_almost_full  out  registered almost-full flag
//   w_overflow     out  sticky: write attempted while full; cleared by rst
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_THRESH = DEFAULT_AFULL_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_inc,
  input  logic [ADDR_WIDTH:0]   sync_rptr,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  w_full,
  output logic                  w_almost_full,
  output logic                  w_overflow
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic          w_full_q, w_full_d;
  logic          w_almost_full_q, w_almost_full_d;
  logic          w_overflow_q, w_overflow_d;
  logic          accept;
  logic [PW-1:0] full_pattern;

  // NOTE: combinational blocks use blocking '=' and assign every output first
  // so no latch is inferred; state is only ever updated with '<=' below.
  always_comb begin
    accept       = w_inc & ~w_full_q;
    wbin_d       = wbin_q + {{(PW-1){1'b0}}, accept};
    wptr_d       = PW'(bin_to_gray(MAX_PTR_WIDTH'(wbin_d)));
    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that means the two MSBs differ and the rest match.
    full_pattern = {~sync_rptr[PW-1:PW-2], sync_rptr[PW-3:0]};
    w_full_d     = (wptr_d == full_pattern);
    w_overflow_d = w_overflow_q | (w_inc & w_full_q);
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [PW-1:0] AFULL_LEVEL = PW'(AFULL_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] occupancy;

  gray2bin #(
    .WIDTH (PW)
  ) u_rptr_gray2bin (
    .gray (sync_rptr),
    .bin  (rbin)
  );

  // Uses the post-write pointer so the flag lines up with w_full timing; the
  // synchronized read pointer lags, so occupancy can only be overestimated.
  always_comb begin
    occupancy       = wbin_d - rbin;
    w_almost_full_d = (occupancy >= AFULL_LEVEL);
  end
`else
  always_comb begin
    w_almost_full_d = 1'b0;
  end
`endif

  // NOTE: reset is synchronous and takes priority over any write request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q          <= '0;
      wptr_q          <= '0;
      w_full_q        <= 1'b0;
      w_almost_full_q <= 1'b0;
      w_overflow_q    <= 1'b0;
    end else begin
      wbin_q          <= wbin_d;
      wptr_q          <= wptr_d;
      w_full_q        <= w_full_d;
      w_almost_full_q <= w_almost_full_d;
      w_overflow_q    <= w_overflow_d;
    end
  end

  assign w_en          = accept;
  assign w_addr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr          = wptr_q;
  assign w_full        = w_full_q;
  assign w_almost_full = w_almost_full_q;
  assign w_overflow    = w_overflow_q;

endmodule : fifo_wr_ctrl

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
// Scoreboard bench for fifo_wr_ctrl with ADDR_WIDTH=3, AFULL_THRESH=6.
// The stimulus process drives inputs on the falling edge and pushes the
// expected response; the monitor pops each entry, checks w_en before the
// rising edge and the registered outputs just after it.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_inc;
  logic [3:0] sync_rptr;
  logic       w_en;
  logic [2:0] w_addr;
  logic [3:0] wptr;
  logic       w_full;
  logic       w_almost_full;
  logic       w_overflow;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic       is_rst;
    logic       en;
    logic [2:0] addr;
    logic [3:0] wptr;
    logic       full;
    logic       afull;
    logic       ovf;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  // Model state: writes accepted (mod 16) and flag values after the last edge.
  int   m_w    = 0;
  logic m_full = 1'b0;
  logic m_ovf  = 1'b0;
  logic m_af   = 1'b0;

  always #5 clk = ~clk;

  fifo_wr_ctrl #(
    .ADDR_WIDTH   (3),
    .AFULL_THRESH (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .w_inc         (w_inc),
    .sync_rptr     (sync_rptr),
    .w_en          (w_en),
    .w_addr        (w_addr),
    .wptr          (wptr),
    .w_full        (w_full),
    .w_almost_full (w_almost_full),
    .w_overflow    (w_overflow)
  );

  // Hand-written 4-bit Gray sequence.
  function automatic logic [3:0] gray4(input int n);
    case (n % 16)
      0: return 4'b0000;   1: return 4'b0001;   2: return 4'b0011;   3: return 4'b0010;
      4: return 4'b0110;   5: return 4'b0111;   6: return 4'b0101;   7: return 4'b0100;
      8: return 4'b1100;   9: return 4'b1101;  10: return 4'b1111;  11: return 4'b1110;
      12: return 4'b1010; 13: return 4'b1011;  14: return 4'b1001;  default: return 4'b1000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; rb is the read count (binary) presented as Gray.
  task automatic step(input logic inc, input int rb, input logic do_rst, input string name);
    exp_t e;
    int   occ;
    @(negedge clk);
    rst       = do_rst;
    w_inc     = inc;
    sync_rptr = gray4(rb);
    e.is_rst  = do_rst;
    e.en      = inc & ~m_full;
    if (do_rst) begin
      m_w = 0; m_full = 1'b0; m_ovf = 1'b0; m_af = 1'b0;
    end else begin
      if (inc && m_full) m_ovf = 1'b1;
      if (e.en) m_w = (m_w + 1) % 16;
      occ    = (m_w - (rb % 16) + 16) % 16;
      m_full = (occ == 8);
`ifdef FIFO_WR_ALMOST_FULL_EN
      m_af   = (occ >= 6);
`else
      m_af   = 1'b0;
`endif
    end
    e.addr  = 3'(m_w % 8);
    e.wptr  = gray4(m_w);
    e.full  = m_full;
    e.afull = m_af;
    e.ovf   = m_ovf;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Monitor: w_en is combinational, so it is sampled before the edge; the
  // registered outputs are sampled 1 time unit after the edge.
  initial begin : monitor
    exp_t       e;
    string      nm;
    logic [3:0] prev_wptr;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, ".w_en"}, 32'(w_en), 32'(e.en));
        prev_wptr = wptr;
        @(posedge clk);
        #1;
        check({nm, ".w_addr"},        32'(w_addr),        32'(e.addr));
        check({nm, ".wptr"},          32'(wptr),          32'(e.wptr));
        check({nm, ".w_full"},        32'(w_full),        32'(e.full));
        check({nm, ".w_almost_full"}, 32'(w_almost_full), 32'(e.afull));
        check({nm, ".w_overflow"},    32'(w_overflow),    32'(e.ovf));
        if (!e.is_rst && e.en)
          check({nm, ".gray_one_bit"}, 32'($countones(prev_wptr ^ wptr)), 32'd1);
      end
    end
  end

  initial begin : stimulus
    int rb;
    rst = 1'b1; w_inc = 1'b0; sync_rptr = 4'b0000;

    // Reset: all registered outputs at zero.
    step(1'b0, 0, 1'b1, "reset0");
    step(1'b0, 0, 1'b1, "reset1");
    step(1'b0, 0, 1'b0, "idle");

    // Fill: 8 writes, full rises on the 8th edge (wptr 1100).
    for (int i = 0; i < 8; i++) step(1'b1, 0, 1'b0, "fill");

    // Overflow: writes while full are dropped, flag sticks after w_inc drops.
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b0, "overflow");
    for (int i = 0; i < 2; i++) step(1'b0, 0, 1'b0, "ovf_hold");

    // Drain release: one read becomes visible, full clears, write at addr 0.
    step(1'b0, 1, 1'b0, "drain_release");
    step(1'b1, 1, 1'b0, "drain_write");

    // Wrap: 16 writes with the read pointer trailing by two.
    step(1'b0, 0, 1'b1, "wrap_reset");
    for (int i = 0; i < 16; i++) begin
      rb = (i >= 2) ? i - 2 : 0;
      step(1'b1, rb, 1'b0, "wrap");
    end
    step(1'b0, 16, 1'b0, "wrap_catchup");

    // Almost-full: 6 writes with sync_rptr = 0.
    step(1'b0, 0, 1'b1, "af_reset");
    for (int i = 0; i < 6; i++) step(1'b1, 0, 1'b0, "almost_full");

    // Reset mid-operation with w_inc held high.
    step(1'b0, 0, 1'b1, "mid_reset_pre");
    for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b0, "mid_fill");
    step(1'b1, 0, 1'b1, "mid_reset");
    step(1'b0, 0, 1'b0, "post_reset_idle");

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_fifo_wr_ctrl
